// File: rtl/lbus_tx_frame_checker_if.sv
// LBUS TX segment bundle between the AXIS-to-LBUS adapter (master) and the DCMAC
// TX port or a passive frame checker (slave).
interface lbus_tx_frame_checker_if;
  logic [1023:0] lbus_txdatain;
  logic [7:0]    lbus_txenain;
  logic [7:0]    lbus_txsopin;
  logic [7:0]    lbus_txeopin;
  logic [7:0]    lbus_txerrin;
  logic [31:0]   lbus_txmtyin;
  logic          lbus_tx_rdyout;

  modport master (
    output lbus_txdatain, lbus_txenain, lbus_txsopin, lbus_txeopin,
    output lbus_txerrin, lbus_txmtyin,
    input  lbus_tx_rdyout
  );

  modport slave (
    input  lbus_txdatain, lbus_txenain, lbus_txsopin, lbus_txeopin,
    input  lbus_txerrin, lbus_txmtyin,
    output lbus_tx_rdyout
  );
endinterface

// File: rtl/lbus_tx_frame_checker.sv
// Passive 8-segment LBUS TX framing checker: walks segments 0..7 each cycle,
// measures frame lengths and keeps good/error statistics with one cycle of latency.
module lbus_tx_frame_checker #(
  parameter int G_MIN_FRAME_BYTES = 60,
  parameter int G_MAX_FRAME_BYTES = 9600,
  parameter int G_COUNT_WIDTH     = 32
) (
  input  logic                         lbus_txclk,
  input  logic                         lbus_txreset,
  lbus_tx_frame_checker_if.slave       lbus_tx,
  input  logic                         counters_reset,
  input  logic [15:0]                  expected_packet_length,
  output logic [G_COUNT_WIDTH-1:0]     good_packet_count,
  output logic [G_COUNT_WIDTH-1:0]     good_byte_count,
  output logic [15:0]                  framing_error_count,
  output logic [15:0]                  length_error_count,
  output logic [15:0]                  errflag_packet_count,
  output logic [15:0]                  last_packet_length,
  output logic                         packet_done,
  output logic                         in_packet
);

  localparam logic [15:0] MIN_LEN = 16'(G_MIN_FRAME_BYTES);
  localparam logic [15:0] MAX_LEN = 16'(G_MAX_FRAME_BYTES);

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t                     state_q, state_d;
  logic [15:0]                acc_q, acc_d;
  logic [4:0]                 ferr_inc;
  logic [3:0]                 lerr_inc;
  logic [3:0]                 eflag_inc;
  logic [3:0]                 good_inc;
  logic [G_COUNT_WIDTH-1:0]   bytes_inc;
  logic                       any_close;
  logic [15:0]                close_len;
  logic                       gap;
  logic [1:0]                 rdy_q;
  logic                       unused_data;

  assign unused_data          = ^lbus_tx.lbus_txdatain;
  assign lbus_tx.lbus_tx_rdyout = rdy_q[1];
  assign in_packet            = (state_q == IN_PKT);

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [4:0] b);
    logic [16:0] t;
    t = {1'b0, a} + {12'b0, b};
    return t[16] ? 16'hFFFF : t[15:0];
  endfunction

  // Segment chain: state and accumulator ripple from segment 0 up to segment 7.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ferr_inc  = '0;
    lerr_inc  = '0;
    eflag_inc = '0;
    good_inc  = '0;
    bytes_inc = '0;
    any_close = 1'b0;
    close_len = last_packet_length;
    gap       = 1'b0;
    for (int unsigned s = 0; s < 8; s++) begin
      logic [2:0]  idx;
      logic        ena, sop, eop, err, live, len_bad;
      logic [3:0]  mty, mty_eff;
      logic [15:0] len;
      idx     = 3'(s);
      ena     = lbus_tx.lbus_txenain[idx];
      sop     = lbus_tx.lbus_txsopin[idx];
      eop     = lbus_tx.lbus_txeopin[idx];
      err     = lbus_tx.lbus_txerrin[idx];
      mty     = lbus_tx.lbus_txmtyin[{idx, 2'b00} +: 4];
      mty_eff = mty;
      live    = 1'b0;
      len     = '0;
      len_bad = 1'b0;
      if (!ena) begin
        gap = 1'b1;
        if (sop || eop || (mty != '0)) ferr_inc = ferr_inc + 5'd1;
      end else if (gap) begin
        ferr_inc = ferr_inc + 5'd1;
      end else begin
        if ((mty != '0) && !eop) begin
          ferr_inc = ferr_inc + 5'd1;
          mty_eff  = '0;
        end
        live = 1'b1;
        if (sop) begin
          if (state_d == IN_PKT) ferr_inc = ferr_inc + 5'd1;
          state_d = IN_PKT;
          acc_d   = 16'd16;
        end else if (state_d == IDLE) begin
          ferr_inc = ferr_inc + 5'd1;
          live     = 1'b0;
        end else begin
          acc_d = (acc_d > 16'hFFEF) ? 16'hFFFF : acc_d + 16'd16;
        end
      end
      len     = acc_d - {12'b0, mty_eff};
      len_bad = (len < MIN_LEN) || (len > MAX_LEN) ||
                ((expected_packet_length != '0) && (len != expected_packet_length));
      if (live && eop) begin
        state_d   = IDLE;
        any_close = 1'b1;
        close_len = len;
        if (err) begin
          eflag_inc = eflag_inc + 4'd1;
        end else if (len_bad) begin
          lerr_inc = lerr_inc + 4'd1;
        end else begin
          good_inc  = good_inc + 4'd1;
          bytes_inc = bytes_inc + G_COUNT_WIDTH'(len);
        end
      end
    end
  end

  always_ff @(posedge lbus_txclk) begin
    if (lbus_txreset) begin
      state_q <= IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  // A counters_reset cycle wins over closures in that same cycle.
  always_ff @(posedge lbus_txclk) begin
    if (lbus_txreset) begin
      rdy_q                <= '0;
      packet_done          <= 1'b0;
      good_packet_count    <= '0;
      good_byte_count      <= '0;
      framing_error_count  <= '0;
      length_error_count   <= '0;
      errflag_packet_count <= '0;
      last_packet_length   <= '0;
    end else begin
      rdy_q       <= {rdy_q[0], 1'b1};
      packet_done <= any_close;
      if (counters_reset) begin
        good_packet_count    <= '0;
        good_byte_count      <= '0;
        framing_error_count  <= '0;
        length_error_count   <= '0;
        errflag_packet_count <= '0;
        last_packet_length   <= '0;
      end else begin
        good_packet_count    <= good_packet_count + G_COUNT_WIDTH'(good_inc);
        good_byte_count      <= good_byte_count + bytes_inc;
        framing_error_count  <= sat_add16(framing_error_count, ferr_inc);
        length_error_count   <= sat_add16(length_error_count, {1'b0, lerr_inc});
        errflag_packet_count <= sat_add16(errflag_packet_count, {1'b0, eflag_inc});
        last_packet_length   <= close_len;
      end
    end
  end

endmodule

// File: tb/tb_lbus_tx_frame_checker.sv
// Bench for lbus_tx_frame_checker: directed frame scenarios plus randomized
// segment traffic against a frame-level reference model.
module tb_lbus_tx_frame_checker;
  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 9600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        crst = 1'b0;
  logic [15:0] epl = '0;
  logic [31:0] good_cnt, byte_cnt;
  logic [15:0] ferr, lerr, eflag, last_len;
  logic        done, inpkt;

  int tests = 0;
  int fails = 0;

  bit          m_open = 0;
  int          m_segs = 0;
  logic [31:0] m_good = '0;
  logic [31:0] m_bytes = '0;
  int          m_ferr = 0, m_lerr = 0, m_eflag = 0, m_last = 0;
  bit          m_done = 0;
  int          done_seen = 0;

  lbus_tx_frame_checker_if bus ();

  always #5 clk = ~clk;

  lbus_tx_frame_checker #(
    .G_MIN_FRAME_BYTES(60),
    .G_MAX_FRAME_BYTES(9600),
    .G_COUNT_WIDTH(32)
  ) dut (
    .lbus_txclk            (clk),
    .lbus_txreset          (rst),
    .lbus_tx               (bus.slave),
    .counters_reset        (crst),
    .expected_packet_length(epl),
    .good_packet_count     (good_cnt),
    .good_byte_count       (byte_cnt),
    .framing_error_count   (ferr),
    .length_error_count    (lerr),
    .errflag_packet_count  (eflag),
    .last_packet_length    (last_len),
    .packet_done           (done),
    .in_packet             (inpkt)
  );

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Drive one input cycle, advance the frame-level model, sample outputs #1 after the edge.
  task automatic step(input logic [7:0] ena, input logic [7:0] sop, input logic [7:0] eop,
                      input logic [7:0] err, input logic [31:0] mty);
    int n, fe, gd, le, ef, len, last_c;
    bit any;
    logic [31:0] bd;
    bus.lbus_txenain  = ena;
    bus.lbus_txsopin  = sop;
    bus.lbus_txeopin  = eop;
    bus.lbus_txerrin  = err;
    bus.lbus_txmtyin  = mty;
    bus.lbus_txdatain = {32{$urandom()}};
    n = 0;
    while (n < 8 && ena[n]) n++;
    fe = 0; gd = 0; le = 0; ef = 0; bd = '0; any = 0; last_c = 0;
    for (int s = 0; s < 8; s++) begin
      int mtv;
      mtv = int'(mty[4*s +: 4]);
      if (s >= n) begin
        if (ena[s] || sop[s] || eop[s] || mtv != 0) fe++;
        continue;
      end
      if (mtv != 0 && !eop[s]) begin fe++; mtv = 0; end
      if (sop[s]) begin
        if (m_open) fe++;
        m_open = 1; m_segs = 1;
      end else if (!m_open) begin
        fe++;
        continue;
      end else m_segs++;
      if (eop[s]) begin
        len = ((m_segs * 16 > 65535) ? 65535 : m_segs * 16) - mtv;
        m_open = 0; any = 1; last_c = len;
        if (err[s]) ef++;
        else if (len < MIN_LEN || len > MAX_LEN || (epl != 0 && len != int'(epl))) le++;
        else begin gd++; bd += 32'(len); end
      end
    end
    if (crst) begin
      m_good = '0; m_bytes = '0; m_ferr = 0; m_lerr = 0; m_eflag = 0; m_last = 0;
    end else begin
      m_good  += 32'(gd);
      m_bytes += bd;
      m_ferr  = sat16(m_ferr + fe);
      m_lerr  = sat16(m_lerr + le);
      m_eflag = sat16(m_eflag + ef);
      if (any) m_last = last_c;
    end
    m_done = any;
    @(posedge clk); #1;
    if (done) done_seen++;
  endtask

  task automatic idle();
    step(8'h00, 8'h00, 8'h00, 8'h00, 32'h0);
  endtask

  task automatic clear_counters();
    crst = 1'b1;
    idle();
    crst = 1'b0;
  endtask

  // Stream nframes 8234-byte frames (515 segments, mty 6 on eop) packed back to back.
  task automatic send_stream(input int nframes, input logic errbit);
    int total, g, p;
    total = 515 * nframes;
    g = 0;
    while (g < total) begin
      logic [7:0] e, so, eo, er;
      logic [31:0] my;
      e = '0; so = '0; eo = '0; er = '0; my = '0;
      for (int s = 0; s < 8 && g < total; s++) begin
        p = g % 515;
        e[s] = 1'b1;
        if (p == 0) so[s] = 1'b1;
        if (p == 514) begin eo[s] = 1'b1; er[s] = errbit; my[4*s +: 4] = 4'd6; end
        g++;
      end
      step(e, so, eo, er, my);
    end
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    bus.lbus_txenain = '0; bus.lbus_txsopin = '0; bus.lbus_txeopin = '0;
    bus.lbus_txerrin = '0; bus.lbus_txmtyin = '0;
    repeat (cycles) @(posedge clk);
    #1;
    m_open = 0; m_segs = 0; m_good = '0; m_bytes = '0;
    m_ferr = 0; m_lerr = 0; m_eflag = 0; m_last = 0; m_done = 0;
    tests++; if (bus.lbus_tx_rdyout !== 1'b0) begin fails++; $display("FAIL rdy_in_reset: got %b want 0", bus.lbus_tx_rdyout); end
    tests++; if (good_cnt !== 32'd0 || byte_cnt !== 32'd0) begin fails++; $display("FAIL reset_good: got %0d/%0d want 0/0", good_cnt, byte_cnt); end
    tests++; if (ferr !== 16'd0 || lerr !== 16'd0 || eflag !== 16'd0) begin fails++; $display("FAIL reset_err: got %0d/%0d/%0d want 0/0/0", ferr, lerr, eflag); end
    tests++; if (last_len !== 16'd0 || done !== 1'b0 || inpkt !== 1'b0) begin fails++; $display("FAIL reset_misc: got last=%0d done=%b inpkt=%b want 0", last_len, done, inpkt); end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (bus.lbus_tx_rdyout !== 1'b0) begin fails++; $display("FAIL rdy_first_cycle: got %b want 0", bus.lbus_tx_rdyout); end
    @(posedge clk); #1;
    tests++; if (bus.lbus_tx_rdyout !== 1'b1) begin fails++; $display("FAIL rdy_second_cycle: got %b want 1", bus.lbus_tx_rdyout); end
  endtask

  task automatic test_reset();
    apply_reset(3);
  endtask

  task automatic test_jumbo();
    clear_counters();
    epl = 16'd8234;
    done_seen = 0;
    send_stream(1, 1'b0);
    tests++; if (good_cnt !== 32'd1) begin fails++; $display("FAIL jumbo_good: got %0d want 1", good_cnt); end
    tests++; if (byte_cnt !== 32'd8234) begin fails++; $display("FAIL jumbo_bytes: got %0d want 8234", byte_cnt); end
    tests++; if (last_len !== 16'd8234) begin fails++; $display("FAIL jumbo_last: got %0d want 8234", last_len); end
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL jumbo_done: got %b want 1", done); end
    idle();
    tests++; if (done !== 1'b0 || done_seen != 1) begin fails++; $display("FAIL jumbo_done_pulse: got done=%b pulses=%0d want 0/1", done, done_seen); end
  endtask

  task automatic test_back_to_back();
    clear_counters();
    epl = 16'd8234;
    send_stream(3, 1'b0);
    tests++; if (good_cnt !== 32'd3) begin fails++; $display("FAIL b2b_good: got %0d want 3", good_cnt); end
    tests++; if (byte_cnt !== 32'd24702) begin fails++; $display("FAIL b2b_bytes: got %0d want 24702", byte_cnt); end
    tests++; if (ferr !== 16'd0) begin fails++; $display("FAIL b2b_ferr: got %0d want 0", ferr); end
    idle();
  endtask

  task automatic test_runt();
    clear_counters();
    epl = 16'd0;
    step(8'h07, 8'h01, 8'h04, 8'h00, 32'h0);
    tests++; if (lerr !== 16'd1) begin fails++; $display("FAIL runt_lerr: got %0d want 1", lerr); end
    tests++; if (good_cnt !== 32'd0) begin fails++; $display("FAIL runt_good: got %0d want 0", good_cnt); end
    tests++; if (last_len !== 16'd48) begin fails++; $display("FAIL runt_last: got %0d want 48", last_len); end
  endtask

  task automatic test_errflag();
    clear_counters();
    epl = 16'd8234;
    send_stream(1, 1'b1);
    tests++; if (eflag !== 16'd1) begin fails++; $display("FAIL errflag_count: got %0d want 1", eflag); end
    tests++; if (lerr !== 16'd0 || good_cnt !== 32'd0) begin fails++; $display("FAIL errflag_other: got lerr=%0d good=%0d want 0/0", lerr, good_cnt); end
    idle();
  endtask

  task automatic test_violations();
    clear_counters();
    epl = 16'd0;
    step(8'h05, 8'h01, 8'h00, 8'h00, 32'h0);
    tests++; if (ferr !== 16'd1 || inpkt !== 1'b1) begin fails++; $display("FAIL viol_gap: got ferr=%0d inpkt=%b want 1/1", ferr, inpkt); end
    step(8'h01, 8'h01, 8'h00, 8'h00, 32'h0);
    tests++; if (ferr !== 16'd2) begin fails++; $display("FAIL viol_sop_in_pkt: got %0d want 2", ferr); end
    step(8'h00, 8'h00, 8'h01, 8'h00, 32'h0);
    tests++; if (ferr !== 16'd3 || inpkt !== 1'b1) begin fails++; $display("FAIL viol_eop_disabled: got ferr=%0d inpkt=%b want 3/1", ferr, inpkt); end
    step(8'h01, 8'h00, 8'h01, 8'h00, 32'h0);
    tests++; if (lerr !== 16'd1 || last_len !== 16'd32 || inpkt !== 1'b0) begin fails++; $display("FAIL viol_close: got lerr=%0d last=%0d inpkt=%b want 1/32/0", lerr, last_len, inpkt); end
    step(8'h01, 8'h00, 8'h00, 8'h00, 32'h0);
    tests++; if (ferr !== 16'd4) begin fails++; $display("FAIL viol_idle_data: got %0d want 4", ferr); end
    tests++; if (good_cnt !== 32'd0 || eflag !== 16'd0) begin fails++; $display("FAIL viol_abandoned: got good=%0d eflag=%0d want 0/0", good_cnt, eflag); end
  endtask

  task automatic test_reset_mid_frame();
    epl = 16'd8234;
    step(8'hFF, 8'h01, 8'h00, 8'h00, 32'h0);
    repeat (9) step(8'hFF, 8'h00, 8'h00, 8'h00, 32'h0);
    apply_reset(2);
    send_stream(1, 1'b0);
    tests++; if (good_cnt !== 32'd1 || byte_cnt !== 32'd8234) begin fails++; $display("FAIL rstmid_good: got %0d/%0d want 1/8234", good_cnt, byte_cnt); end
    tests++; if (ferr !== 16'd0 || lerr !== 16'd0) begin fails++; $display("FAIL rstmid_err: got ferr=%0d lerr=%0d want 0/0", ferr, lerr); end
    idle();
  endtask

  task automatic test_counters_reset();
    epl = 16'd0;
    step(8'h00, 8'h01, 8'h00, 8'h00, 32'h0);
    step(8'hFF, 8'h01, 8'h00, 8'h00, 32'h0);
    crst = 1'b1;
    step(8'hFF, 8'h00, 8'h00, 8'h00, 32'h0);
    crst = 1'b0;
    tests++; if (ferr !== 16'd0 || good_cnt !== 32'd0 || last_len !== 16'd0) begin fails++; $display("FAIL crst_clear: got ferr=%0d good=%0d last=%0d want 0", ferr, good_cnt, last_len); end
    tests++; if (inpkt !== 1'b1) begin fails++; $display("FAIL crst_state: got inpkt=%b want 1", inpkt); end
    step(8'hFF, 8'h00, 8'h00, 8'h00, 32'h0);
    step(8'h0F, 8'h00, 8'h08, 8'h00, 32'h0000_4000);
    tests++; if (good_cnt !== 32'd1 || byte_cnt !== 32'd444 || last_len !== 16'd444) begin fails++; $display("FAIL crst_inflight: got %0d/%0d/%0d want 1/444/444", good_cnt, byte_cnt, last_len); end
  endtask

  task automatic test_saturation();
    clear_counters();
    repeat (4200) step(8'hFF, 8'hFF, 8'h00, 8'h00, 32'h1111_1111);
    tests++; if (ferr !== 16'hFFFF || int'(ferr) != m_ferr) begin fails++; $display("FAIL sat_ferr: got %0d want 65535 (model %0d)", ferr, m_ferr); end
    step(8'h01, 8'h00, 8'h01, 8'h00, 32'h0);
    tests++; if (ferr !== 16'hFFFF || lerr !== 16'd1) begin fails++; $display("FAIL sat_hold: got ferr=%0d lerr=%0d want 65535/1", ferr, lerr); end
    clear_counters();
  endtask

  task automatic test_random();
    int k;
    logic [7:0] e, so, eo, er;
    logic [31:0] my;
    clear_counters();
    epl = 16'd0;
    for (int c = 0; c < 2000; c++) begin
      if (c == 1400) epl = 16'd96;
      k = $urandom_range(0, 8);
      e = 8'((1 << k) - 1);
      if ($urandom_range(0, 7) == 0) e = 8'($urandom());
      so = '0; eo = '0; er = '0; my = '0;
      for (int s = 0; s < 8; s++) begin
        if ($urandom_range(0, 7) == 0) so[s] = 1'b1;
        if ($urandom_range(0, 5) == 0) eo[s] = 1'b1;
        if ($urandom_range(0, 3) == 0) er[s] = 1'b1;
        if ($urandom_range(0, 4) == 0) my[4*s +: 4] = 4'($urandom());
      end
      step(e, so, eo, er, my);
      tests++; if (good_cnt !== m_good) begin fails++; $display("FAIL rnd_good c=%0d: got %0d want %0d", c, good_cnt, m_good); end
      tests++; if (byte_cnt !== m_bytes) begin fails++; $display("FAIL rnd_bytes c=%0d: got %0d want %0d", c, byte_cnt, m_bytes); end
      tests++; if (int'(ferr) != m_ferr) begin fails++; $display("FAIL rnd_ferr c=%0d: got %0d want %0d", c, ferr, m_ferr); end
      tests++; if (int'(lerr) != m_lerr) begin fails++; $display("FAIL rnd_lerr c=%0d: got %0d want %0d", c, lerr, m_lerr); end
      tests++; if (int'(eflag) != m_eflag) begin fails++; $display("FAIL rnd_eflag c=%0d: got %0d want %0d", c, eflag, m_eflag); end
      tests++; if (int'(last_len) != m_last) begin fails++; $display("FAIL rnd_last c=%0d: got %0d want %0d", c, last_len, m_last); end
      tests++; if (done !== m_done || inpkt !== m_open) begin fails++; $display("FAIL rnd_flags c=%0d: got done=%b inpkt=%b want %b/%b", c, done, inpkt, m_done, m_open); end
    end
  endtask

  initial begin
    bus.lbus_txdatain = '0; bus.lbus_txenain = '0; bus.lbus_txsopin = '0;
    bus.lbus_txeopin = '0; bus.lbus_txerrin = '0; bus.lbus_txmtyin = '0;
    test_reset();
    test_jumbo();
    test_back_to_back();
    test_runt();
    test_errflag();
    test_violations();
    test_reset_mid_frame();
    test_counters_reset();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule

// File: doc/lbus_tx_frame_checker.md
Name: lbus_tx_frame_checker

Overview:
- Passive checker on the 8-segment 400G LBUS TX path. It consumes the segment outputs of the AXIS-to-LBUS TX adapter, i.e. what is presented to the DCMAC TX port.
- Tracks packet framing per segment (sop/ena/eop/mty/err) and measures each frame's byte length.
- Keeps good/error counters and drives the LBUS ready back to the adapter, so simulation benches and on-chip debug can confirm the UDP/IP stream is well framed.

Parameters:
- G_MIN_FRAME_BYTES, 60, smallest legal frame length (no FCS); anything shorter is a runt.
- G_MAX_FRAME_BYTES, 9600, largest legal frame length; anything longer is a giant.
- G_COUNT_WIDTH, 32, width of the good-packet and byte counters.

Ports:
- lbus_txclk  in  1  single clock.
- lbus_txreset  in  1  synchronous, active-high reset.
- lbus_txdatain  in  1024  segment s data = bits [128s+127:128s]; ignored except for width consistency.
- lbus_txenain  in  8  segment enables; bit s = segment s.
- lbus_txsopin  in  8  start-of-packet per segment.
- lbus_txeopin  in  8  end-of-packet per segment.
- lbus_txerrin  in  8  error flag per segment; meaningful only with eop.
- lbus_txmtyin  in  32  empty-byte count per segment, segment s = bits [4s+3:4s].
- lbus_tx_rdyout  out  1  ready to the adapter.
- counters_reset  in  1  synchronous clear of all counters and sticky flags.
- expected_packet_length  in  16  bytes; 0 disables the mismatch check.
- good_packet_count  out  G_COUNT_WIDTH  frames closed with no error.
- good_byte_count  out  G_COUNT_WIDTH  sum of good frame lengths.
- framing_error_count  out  16  protocol violations (saturating).
- length_error_count  out  16  runt/giant/mismatch frames (saturating).
- errflag_packet_count  out  16  frames closed with err=1 on eop (saturating).
- last_packet_length  out  16  length of the most recently closed frame.
- packet_done  out  1  pulse: at least one frame closed in the previous cycle.
- in_packet  out  1  checker is inside a frame at the end of the previous cycle.

Behaviour:
- Reset:
  - All counts, last_packet_length, packet_done, in_packet = 0; state = IDLE; lbus_tx_rdyout = 0.
  - lbus_tx_rdyout goes to 1 on the second cycle after reset deasserts and then stays 1.
  - Reset mid-frame discards the partial frame; nothing is counted.
- Segment processing:
  - Each cycle, segments 0..7 are evaluated in order by a combinational chain.
  - State (IDLE/IN_PKT) and the running byte accumulator (16 bits, saturating at 0xFFFF) pass from segment to segment, then are registered at cycle end.
- Enables:
  - Enabled segments must be contiguous from segment 0.
  - An enabled segment above a disabled one is a framing error; that segment is ignored.
- Disabled segment: sop, eop or nonzero mty is a framing error; the flags are ignored and the segment is otherwise skipped.
- IDLE state:
  - Enabled segment without sop: framing error, segment dropped.
  - Enabled segment with sop: go to IN_PKT, accumulator = 16.
- IN_PKT state:
  - Enabled segment: accumulator += 16.
  - sop while IN_PKT: framing error; the open frame is abandoned (not counted) and a new frame starts at this segment.
- mty nonzero without eop: framing error; the mty value is ignored.
- eop handling:
  - Frame length = accumulator - mty; the segment's bytes are counted before the subtraction. sop and eop in the same segment gives 16 - mty.
  - State returns to IDLE.
- Frame classification at eop, in priority order:
  - err=1 -> errflag_packet_count.
  - else length < G_MIN_FRAME_BYTES, or length > G_MAX_FRAME_BYTES, or (expected_packet_length != 0 and length != expected_packet_length) -> length_error_count.
  - else -> good_packet_count += 1 and good_byte_count += length.
- Multiple events per cycle:
  - Up to 8 frames can close in one cycle (e.g. eop on seg 2 then sop on seg 3).
  - All counters add the per-cycle totals.
  - last_packet_length takes the highest-numbered closing segment's frame.
- Timing: counters, packet_done, last_packet_length and in_packet update one cycle after the input cycle. Fixed latency 1.
- Saturating 16-bit counters hold at 0xFFFF. G_COUNT_WIDTH counters wrap modulo 2^G_COUNT_WIDTH.
- counters_reset clears the counters and last_packet_length only. The framing state is untouched, so a frame in flight is still counted on its eop.
- The checker never modifies the data; lbus_txdatain is unobserved apart from width.

Test Plan:
- 8234-byte frame (UDP 8192 payload + 42 header bytes): 64 cycles with ena=0xFF, then ena=0x07 with eop on seg 2 and mty=6, expected_packet_length=8234 -> good_packet_count=1, good_byte_count=8234, last_packet_length=8234, packet_done pulses once.
- Same frame repeated 3 times back-to-back, the second starting on seg 3 of the first frame's final cycle -> good_packet_count=3, good_byte_count=24702, framing_error_count=0.
- 48-byte frame (ena=0x07, sop seg0, eop seg2, mty=0) -> length_error_count=1, good_packet_count unchanged.
- 8234-byte frame with err=1 on the eop segment -> errflag_packet_count=1, length_error_count=0.
- Protocol violations, one each: ena=0x05; sop while IN_PKT; eop with ena=0; data segment in IDLE -> framing_error_count=4, and the abandoned frame is not counted.
- Assert lbus_txreset mid-frame, then send one good 8234-byte frame -> only that frame is counted (good_packet_count=1). lbus_tx_rdyout is 0 during reset and 1 from the second cycle after.
